// File: rtl/seq_num_alloc_arb.sv
// Round-robin arbiter sharing one sequence-number allocation stream among requesters,
// with per-requester outstanding caps and ownership tracking for commit credit return.
module seq_num_alloc_arb #(
    parameter int p_seq_num_bits    = 5,
    parameter int p_num_req         = 2,
    parameter int p_max_outstanding = 4
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [p_seq_num_bits-1:0]                           gen_seq_num,
    input  logic                                                gen_val,
    output logic                                                gen_rdy,
    input  logic [p_num_req-1:0]                                req_val,
    output logic [p_num_req-1:0]                                req_rdy,
    output logic [p_seq_num_bits-1:0]                           req_seq_num,
    input  logic                                                commit_val,
    input  logic [p_seq_num_bits-1:0]                           commit_seq_num,
    output logic [p_num_req*$clog2(p_max_outstanding+1)-1:0]    outstanding
);

    localparam int CW = $clog2(p_max_outstanding + 1);
    localparam int PW = $clog2(p_num_req);
    localparam int NS = 1 << p_seq_num_bits;
    localparam logic [CW-1:0] MAX_CNT = CW'(p_max_outstanding);

    logic [CW-1:0]        cnt_q [p_num_req];
    logic [CW-1:0]        cnt_d [p_num_req];
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]        owner_q [NS];
    logic [PW-1:0]        owner_d [NS];
    logic [NS-1:0]        owner_val_q, owner_val_d;

    logic [p_num_req-1:0] eligible;
    logic                 any_eligible;
    logic [PW-1:0]        grant;
    logic                 fire;
    logic                 commit_hit;
    logic [PW-1:0]        commit_owner;
    int                   scan_idx;

    // Scan from the farthest slot back toward rr_ptr so the last match wins, i.e. the
    // first eligible requester at or after rr_ptr. The grant does not depend on gen_val.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < p_num_req; i++) begin
            eligible[i] = req_val[i] && (cnt_q[i] < MAX_CNT);
        end
        any_eligible = |eligible;
        grant        = '0;
        scan_idx     = 0;
        for (int k = p_num_req - 1; k >= 0; k--) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= p_num_req) begin
                scan_idx = scan_idx - p_num_req;
            end
            if (eligible[scan_idx]) begin
                grant = PW'(scan_idx);
            end
        end
        gen_rdy = rst & any_eligible;
        fire    = gen_val & gen_rdy;
        req_rdy = '0;
        if (fire) begin
            req_rdy[grant] = 1'b1;
        end
        req_seq_num  = gen_seq_num;
        commit_owner = owner_q[commit_seq_num];
        commit_hit   = commit_val & owner_val_q[commit_seq_num];
    end

    // Commit retires before the fire writes, so a same-number fire re-owns the entry.
    always_comb begin
        owner_d     = owner_q;
        owner_val_d = owner_val_q;
        rr_ptr_d    = rr_ptr_q;
        if (commit_hit) begin
            owner_val_d[commit_seq_num] = 1'b0;
        end
        if (fire) begin
            owner_d[gen_seq_num]     = grant;
            owner_val_d[gen_seq_num] = 1'b1;
            rr_ptr_d = (int'(grant) == p_num_req - 1) ? '0 : grant + 1'b1;
        end
        for (int i = 0; i < p_num_req; i++) begin
            cnt_d[i] = cnt_q[i]
                     + CW'(fire && (grant == PW'(i)))
                     - CW'(commit_hit && (commit_owner == PW'(i)));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < p_num_req; i++) begin
                cnt_q[i] <= '0;
            end
            rr_ptr_q    <= '0;
            owner_val_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_val_q <= owner_val_d;
        end
    end

    // Owner IDs are only meaningful under owner_val, so they need no reset.
    always_ff @(posedge clk) begin
        owner_q <= owner_d;
    end

    always_comb begin
        outstanding = '0;
        for (int i = 0; i < p_num_req; i++) begin
            outstanding[i*CW +: CW] = cnt_q[i];
        end
    end

endmodule

// File: tb/tb_seq_num_alloc_arb.sv
// Directed testbench for seq_num_alloc_arb: reset, round-robin, cap, ownership,
// simultaneous events and sequence-number wrap-around.
module tb_seq_num_alloc_arb;

    localparam int SB = 5;
    localparam int NR = 2;
    localparam int MO = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [SB-1:0] gen_seq_num;
    logic          gen_val;
    logic          gen_rdy;
    logic [NR-1:0] req_val;
    logic [NR-1:0] req_rdy;
    logic [SB-1:0] req_seq_num;
    logic          commit_val;
    logic [SB-1:0] commit_seq_num;
    logic [NR*CW-1:0] outstanding;

    int testsRun    = 0;
    int testsFailed = 0;
    int exp0;
    int exp1;

    seq_num_alloc_arb #(
        .p_seq_num_bits   (SB),
        .p_num_req        (NR),
        .p_max_outstanding(MO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .gen_seq_num   (gen_seq_num),
        .gen_val       (gen_val),
        .gen_rdy       (gen_rdy),
        .req_val       (req_val),
        .req_rdy       (req_rdy),
        .req_seq_num   (req_seq_num),
        .commit_val    (commit_val),
        .commit_seq_num(commit_seq_num),
        .outstanding   (outstanding)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and let combinational outputs settle.
    task automatic applyStimulus(input logic [NR-1:0] rv, input logic gv,
                                 input logic [SB-1:0] gsn, input logic cv,
                                 input logic [SB-1:0] csn);
        @(negedge clk);
        req_val        = rv;
        gen_val        = gv;
        gen_seq_num    = gsn;
        commit_val     = cv;
        commit_seq_num = csn;
        #1;
    endtask

    // Quiet the inputs and pulse the asynchronous reset mid-stream.
    task automatic pulseReset();
        @(negedge clk);
        req_val    = '0;
        gen_val    = 1'b0;
        commit_val = 1'b0;
        rst        = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst            = 1'b0;
        req_val        = '0;
        gen_val        = 1'b0;
        gen_seq_num    = '0;
        commit_val     = 1'b0;
        commit_seq_num = '0;

        // Reset held while requesters and generator are active
        applyStimulus(2'b11, 1'b1, 5'd0, 1'b0, 5'd0);
        checkOutput("reset_gen_rdy", 32'(gen_rdy), 32'd0);
        checkOutput("reset_req_rdy", 32'(req_rdy), 32'd0);
        checkOutput("reset_outstanding", 32'(outstanding), 32'd0);
        req_val = '0;
        gen_val = 1'b0;
        rst     = 1'b1;

        // Round-robin: 01,10,01,10
        applyStimulus(2'b11, 1'b1, 5'd0, 1'b0, 5'd0);
        checkOutput("rr0_gen_rdy", 32'(gen_rdy), 32'd1);
        checkOutput("rr0_req_rdy", 32'(req_rdy), 32'd1);
        checkOutput("rr0_seq", 32'(req_seq_num), 32'd0);
        applyStimulus(2'b11, 1'b1, 5'd1, 1'b0, 5'd0);
        checkOutput("rr1_req_rdy", 32'(req_rdy), 32'd2);
        applyStimulus(2'b11, 1'b1, 5'd2, 1'b0, 5'd0);
        checkOutput("rr2_req_rdy", 32'(req_rdy), 32'd1);
        applyStimulus(2'b11, 1'b1, 5'd3, 1'b0, 5'd0);
        checkOutput("rr3_req_rdy", 32'(req_rdy), 32'd2);
        checkOutput("rr3_seq", 32'(req_seq_num), 32'd3);
        applyStimulus(2'b00, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("rr_outstanding", 32'(outstanding), 32'd18);

        // Owner tracking: commit 1, commit 3, duplicate commit 1
        applyStimulus(2'b00, 1'b0, 5'd0, 1'b1, 5'd1);
        applyStimulus(2'b00, 1'b0, 5'd0, 1'b1, 5'd3);
        checkOutput("own_after_c1", 32'(outstanding), 32'd10);
        applyStimulus(2'b00, 1'b0, 5'd0, 1'b1, 5'd1);
        checkOutput("own_after_c3", 32'(outstanding), 32'd2);
        applyStimulus(2'b00, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("own_dup_ignored", 32'(outstanding), 32'd2);

        // Cap: requester 0 alone fills to 4
        pulseReset();
        applyStimulus(2'b00, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("cap_after_reset", 32'(outstanding), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b01, 1'b1, 5'(i), 1'b0, 5'd0);
            checkOutput("cap_fill_req_rdy", 32'(req_rdy), 32'd1);
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'b01, 1'b1, 5'd4, 1'b0, 5'd0);
            checkOutput("cap_full_gen_rdy", 32'(gen_rdy), 32'd0);
            checkOutput("cap_full_req_rdy", 32'(req_rdy), 32'd0);
            checkOutput("cap_full_cnt", 32'(outstanding), 32'd4);
        end
        applyStimulus(2'b01, 1'b1, 5'd4, 1'b1, 5'd2);
        checkOutput("cap_commit_cycle_gen_rdy", 32'(gen_rdy), 32'd0);
        applyStimulus(2'b01, 1'b1, 5'd4, 1'b0, 5'd0);
        checkOutput("cap_credit_gen_rdy", 32'(gen_rdy), 32'd1);
        checkOutput("cap_credit_req_rdy", 32'(req_rdy), 32'd1);
        checkOutput("cap_credit_cnt", 32'(outstanding), 32'd3);
        applyStimulus(2'b01, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("cap_refill_cnt", 32'(outstanding), 32'd4);
        checkOutput("cap_refill_gen_rdy", 32'(gen_rdy), 32'd0);

        // Simultaneous fire and commit on requester 0, then unknown-number commit
        applyStimulus(2'b00, 1'b0, 5'd0, 1'b1, 5'd0);
        applyStimulus(2'b01, 1'b1, 5'd5, 1'b1, 5'd1);
        checkOutput("sim_req_rdy", 32'(req_rdy), 32'd1);
        checkOutput("sim_pre_cnt", 32'(outstanding), 32'd3);
        applyStimulus(2'b00, 1'b0, 5'd0, 1'b1, 5'd20);
        checkOutput("sim_post_cnt", 32'(outstanding), 32'd3);
        applyStimulus(2'b00, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("sim_unknown_ignored", 32'(outstanding), 32'd3);

        // Same number committed and re-allocated to requester 1 in one cycle
        applyStimulus(2'b10, 1'b1, 5'd3, 1'b1, 5'd3);
        checkOutput("same_req_rdy", 32'(req_rdy), 32'd2);
        applyStimulus(2'b00, 1'b0, 5'd0, 1'b1, 5'd3);
        checkOutput("same_reowned", 32'(outstanding), 32'd10);
        applyStimulus(2'b00, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("same_new_owner_retired", 32'(outstanding), 32'd2);

        // Reset mid-stream drops ownership; old commit must not underflow
        pulseReset();
        applyStimulus(2'b00, 1'b0, 5'd0, 1'b1, 5'd4);
        applyStimulus(2'b00, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("post_reset_commit_ignored", 32'(outstanding), 32'd0);

        // Wrap-around: 40 allocations, in-order commits lagging by 3
        pulseReset();
        exp0 = 0;
        exp1 = 0;
        for (int i = 0; i < 43; i++) begin
            applyStimulus(2'b11, (i < 40), 5'(i), (i >= 3), 5'(i - 3));
            checkOutput("wrap_outstanding", 32'(outstanding), 32'((exp1 << CW) | exp0));
            if (i < 40) begin
                checkOutput("wrap_req_rdy", 32'(req_rdy), (i % 2 == 1) ? 32'd2 : 32'd1);
                if (i % 2 == 1) exp1++;
                else            exp0++;
            end
            if (i >= 3) begin
                if ((i - 3) % 2 == 1) exp1--;
                else                  exp0--;
            end
        end
        applyStimulus(2'b00, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("wrap_drained", 32'(outstanding), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
